// File: rtl/usb_rx_framer_pkg.sv
// Shared constants and types for the USB receive framer: stream marker codes,
// FIFO entry layout, trailer status bits and record states.
package usb_rx_framer_pkg;

  localparam logic [7:0] MARKER  = 8'hA5;
  localparam logic [7:0] SUB_ESC = 8'h00;
  localparam logic [7:0] SUB_HDR = 8'h01;
  localparam logic [7:0] SUB_TRL = 8'h02;

  localparam int ENTRY_W = 26;

  localparam int ST_ERR  = 0;
  localparam int ST_DROP = 1;
  localparam int ST_SAT  = 2;

  localparam logic [11:0] LEN_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    ENT_PAY = 2'd0,
    ENT_HDR = 2'd1,
    ENT_TRL = 2'd2
  } entry_type_e;

  typedef struct packed {
    entry_type_e etype;
    logic [23:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    REC_CLOSED,
    REC_OPEN,
    REC_DISCARD
  } rec_state_e;

endpackage

// File: rtl/framer_fifo.sv
// Single-clock show-ahead FIFO: the head entry is presented on rd_data_o
// whenever the FIFO is non-empty; count_o reports current occupancy.
module framer_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_ok, rd_ok;

  assign wr_ok     = wr_en_i && (count_q != CW'(DEPTH));
  assign rd_ok     = rd_en_i && (count_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

  // NOTE: storage is deliberately not reset; only pointers and count are, so
  // the array maps onto plain RAM and stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/usb_rx_framer.sv
// Time-stamps ULPI receive packets and emits byte-stuffed header/payload/
// trailer records through a FIFO that absorbs host-side stalls.
module usb_rx_framer
  import usb_rx_framer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_active_i,
  input  logic        rx_error_i,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ack_i,
  output logic [15:0] drop_count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  rec_state_e    state_q, state_d;
  logic [23:0]   ts_q, ts_d;
  logic          act_prev_q;
  logic [11:0]   len_q, len_d;
  logic [3:0]    status_q, status_d;
  logic          trl_pend_q, trl_pend_d;
  logic          pay_vld_q, pay_vld_d;
  logic [7:0]    pay_q, pay_d;
  logic [15:0]   drop_q, drop_d;
  logic [2:0]    idx_q, idx_d;

  logic          wr_en;
  entry_t        wr_entry, head;
  logic [ENTRY_W-1:0] rd_raw;
  logic          fifo_empty, pop;
  logic [CW-1:0] fifo_count, free;
  logic          fit2, fit1, rise;
  logic [7:0]    ser_byte;
  logic          ser_last;

  assign free = CW'(DEPTH) - fifo_count;
  assign fit2 = (free >= CW'(2));
  assign fit1 = (free >= CW'(1));
  assign rise = rx_active_i && !act_prev_q && enable_i;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ts_d       = enable_i ? ts_q + 24'd1 : 24'd0;
    len_d      = len_q;
    status_d   = status_q;
    trl_pend_d = 1'b0;
    pay_vld_d  = 1'b0;
    pay_d      = pay_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;
    wr_entry   = '{etype: ENT_PAY, data: 24'd0};

    case (state_q)
      REC_CLOSED: begin
        if (trl_pend_q) begin
          wr_en    = fit1;
          wr_entry = '{etype: ENT_TRL, data: {8'h00, status_q, len_q}};
        end else if (rise) begin
          len_d    = '0;
          status_d = '0;
          if (fit2) begin
            wr_en    = 1'b1;
            wr_entry = '{etype: ENT_HDR, data: ts_q};
            state_d  = REC_OPEN;
          end else begin
            state_d = REC_DISCARD;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end
        end
      end
      REC_OPEN: begin
        if (pay_vld_q) begin
          if (fit2) begin
            wr_en    = 1'b1;
            wr_entry = '{etype: ENT_PAY, data: {16'h0000, pay_q}};
          end else begin
            status_d[ST_DROP] = 1'b1;
          end
        end
        if (rx_active_i) begin
          if (rx_error_i) status_d[ST_ERR] = 1'b1;
          if (rx_valid_i) begin
            pay_vld_d = 1'b1;
            pay_d     = rx_data_i;
            if (len_q == LEN_MAX) status_d[ST_SAT] = 1'b1;
            else                  len_d = len_q + 12'd1;
          end
        end else begin
          state_d    = REC_CLOSED;
          trl_pend_d = 1'b1;
        end
      end
      REC_DISCARD: begin
        if (!rx_active_i) state_d = REC_CLOSED;
      end
      default: state_d = REC_CLOSED;
    endcase
  end

  // Serializer: pick the byte at idx_q of the head entry; last byte pops it.
  always_comb begin
    ser_byte = 8'h00;
    ser_last = 1'b1;
    case (head.etype)
      ENT_PAY: begin
        if (head.data[7:0] == MARKER) begin
          ser_byte = (idx_q == 3'd0) ? MARKER : SUB_ESC;
          ser_last = (idx_q == 3'd1);
        end else begin
          ser_byte = head.data[7:0];
        end
      end
      ENT_HDR: begin
        case (idx_q)
          3'd0:    ser_byte = MARKER;
          3'd1:    ser_byte = SUB_HDR;
          3'd2:    ser_byte = head.data[7:0];
          3'd3:    ser_byte = head.data[15:8];
          default: ser_byte = head.data[23:16];
        endcase
        ser_last = (idx_q == 3'd4);
      end
      ENT_TRL: begin
        case (idx_q)
          3'd0:    ser_byte = MARKER;
          3'd1:    ser_byte = SUB_TRL;
          3'd2:    ser_byte = head.data[7:0];
          default: ser_byte = head.data[15:8];
        endcase
        ser_last = (idx_q == 3'd3);
      end
      default: ser_last = 1'b1;
    endcase
  end

  assign out_valid_o  = !fifo_empty;
  assign out_data_o   = out_valid_o ? ser_byte : 8'h00;
  assign pop          = out_valid_o && out_ack_i && ser_last;
  assign idx_d        = (out_valid_o && out_ack_i) ? (ser_last ? 3'd0 : idx_q + 3'd1) : idx_q;
  assign drop_count_o = drop_q;
  assign head         = entry_t'(rd_raw);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= REC_CLOSED;
      ts_q       <= '0;
      act_prev_q <= 1'b0;
      len_q      <= '0;
      status_q   <= '0;
      trl_pend_q <= 1'b0;
      pay_vld_q  <= 1'b0;
      pay_q      <= '0;
      drop_q     <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      act_prev_q <= rx_active_i;
      len_q      <= len_d;
      status_q   <= status_d;
      trl_pend_q <= trl_pend_d;
      pay_vld_q  <= pay_vld_d;
      pay_q      <= pay_d;
      drop_q     <= drop_d;
      idx_q      <= idx_d;
    end
  end

  framer_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_raw),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule
